// File: rtl/rv_fetch_if.sv
// Fetch-stage signal bundle: instruction-bus request/response, core delivery, redirect.
// Latency: none, wires only.
// Backpressure: req_ready stalls issue and inst_ready stalls delivery; the response side has no backpressure.
//
// Ports (master = rv_fetch side):
//   req_valid/req_ready/req_addr  : word-aligned fetch request to the instruction bus
//   rsp_valid/rsp_data            : in-order read data; cannot be back-pressured
//   inst_valid/inst_ready/inst/inst_pc : instruction handed to the core
//   redirect/redirect_pc          : core restart request and target
interface rv_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc,
        input  req_ready, rsp_valid, rsp_data, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc,
        output req_ready, rsp_valid, rsp_data, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/rv_fetch.sv
// Instruction fetch stage: in-order word fetches buffered with their PCs in a DEPTH-entry queue.
// Latency: request accepted in cycle 0, response in cycle 1, inst_valid in cycle 2 (registered queue, no bypass).
// Backpressure: issue is credit-limited so that count + outstanding never exceeds DEPTH; inst_ready stalls the head.
//
// Ports: clk, rst (synchronous, active-high); bus (rv_fetch_if.master) carrying the request,
// response, instruction and redirect signals; misaligned (only with RV_FETCH_ALIGN_CHECK_EN).
// Optional feature macro: RV_FETCH_ALIGN_CHECK_EN -- a redirect to a non-word-aligned target
// halts fetching and raises misaligned until an aligned redirect or reset. Without it the low
// two bits of redirect_pc are ignored.
module rv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    rv_fetch_if.master    bus
`ifdef RV_FETCH_ALIGN_CHECK_EN
    ,
    output logic          misaligned
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic          halted;
    logic [CW:0]   in_use;
    logic          acc;
    logic          rsp;
    logic          keep;
    logic          deq;
    logic [31:0]   target;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] out_net;

`ifdef RV_FETCH_ALIGN_CHECK_EN
    typedef enum logic {ST_RUN, ST_HALT} state_t;
    state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = (bus.redirect_pc[1:0] != 2'b00) ? ST_HALT : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    assign halted     = (state_q == ST_HALT);
    assign misaligned = halted;
`else
    assign halted = 1'b0;
`endif

    // Credit check: every accepted request is guaranteed a queue slot when it returns.
    assign in_use        = {1'b0, count_q} + {1'b0, outstanding_q};
    assign bus.req_valid = (in_use < (CW+1)'(DEPTH)) && !halted;
    assign bus.req_addr  = fetch_pc_q;

    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = bus.inst_valid ? inst_mem[head_q] : 32'h0;
    assign bus.inst_pc    = bus.inst_valid ? pc_mem[head_q]   : 32'h0;

    assign acc    = bus.req_valid && bus.req_ready;
    assign rsp    = bus.rsp_valid;
    assign deq    = bus.inst_valid && bus.inst_ready && !bus.redirect;
    assign keep   = rsp && (drop_cnt_q == '0) && !bus.redirect;
    assign target = bus.redirect_pc & 32'hFFFF_FFFC;
    assign out_net = outstanding_q + CW'(acc) - CW'(rsp);

    // Once drop_cnt is zero every outstanding request belongs to the current sequential run,
    // so the oldest one sits outstanding words behind fetch_pc. This replaces a side FIFO of PCs.
    assign rsp_pc = fetch_pc_q - 32'({outstanding_q, 2'b00});

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = out_net;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        if (bus.redirect) begin
            // Everything still in flight after this cycle is stale.
            fetch_pc_d = target;
            drop_cnt_d = out_net;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (acc) fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
            count_d = count_q + CW'(keep) - CW'(deq);
            tail_d  = tail_q + AW'(keep);
            head_d  = head_q + AW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    // Queue storage needs no reset: inst/inst_pc are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (keep) begin
            pc_mem[tail_q]   <= rsp_pc;
            inst_mem[tail_q] <= bus.rsp_data;
        end
    end

endmodule

// File: tb/tb_rv_fetch.sv
module tb_rv_fetch;

    logic clk;
    logic rst;
`ifdef RV_FETCH_ALIGN_CHECK_EN
    logic misaligned;
`endif

    rv_fetch_if bus_if();

    rv_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if.master)
`ifdef RV_FETCH_ALIGN_CHECK_EN
        ,
        .misaligned (misaligned)
`endif
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pending[$];
    logic [31:0] sb[$];
    int          cyc;
    int          lat;
    int          n_cmp;
    int          n_fail;
    int          n_acc;
    int          n_cons;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Finish the current cycle (sample handshakes just before the edge), then start the
    // next one at the falling edge by driving that cycle's bus response.
    task automatic tick();
        logic [31:0] p;
        #4;
        if (rst) begin
            pending.delete();
            sb.delete();
        end else begin
            if (bus_if.redirect) begin
                sb.delete();
            end else if (bus_if.inst_valid && bus_if.inst_ready) begin
                n_cons++;
                if (sb.size() == 0) begin
                    check("unexpected_inst", bus_if.inst_pc, 32'hFFFF_FFFF);
                end else begin
                    p = sb.pop_front();
                    check("inst_pc", bus_if.inst_pc, p);
                    check("inst", bus_if.inst, mem_word(p));
                end
            end
            if (bus_if.req_valid && bus_if.req_ready) begin
                n_acc++;
                pending.push_back('{addr: bus_if.req_addr, due: cyc + lat});
                if (!bus_if.redirect) sb.push_back(bus_if.req_addr);
            end
        end
        @(negedge clk);
        cyc++;
        if (pending.size() > 0 && pending[0].due == cyc) begin
            bus_if.rsp_valid = 1'b1;
            bus_if.rsp_data  = mem_word(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            bus_if.rsp_valid = 1'b0;
            bus_if.rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = pc;
        tick();
        bus_if.redirect    = 1'b0;
    endtask

    int a0;
    int c0;

    initial begin
        n_cmp = 0; n_fail = 0; n_acc = 0; n_cons = 0; cyc = 0; lat = 1;
        rst                = 1'b1;
        bus_if.req_ready   = 1'b1;
        bus_if.rsp_valid   = 1'b0;
        bus_if.rsp_data    = 32'h0;
        bus_if.inst_ready  = 1'b1;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 32'h0;
        @(negedge clk);
        tick();

        // Reset state and best-case streaming with a 1-cycle bus.
        reset_dut();
        check("rst_req_valid", bus_if.req_valid, 1);
        check("rst_req_addr", bus_if.req_addr, 32'h100);
        check("rst_inst_valid", bus_if.inst_valid, 0);
        check("rst_inst", bus_if.inst, 0);
        check("rst_inst_pc", bus_if.inst_pc, 0);
`ifdef RV_FETCH_ALIGN_CHECK_EN
        check("rst_misaligned", misaligned, 0);
`endif
        tick();
        check("c1_req_addr", bus_if.req_addr, 32'h104);
        check("c1_inst_valid", bus_if.inst_valid, 0);
        tick();
        check("c2_req_addr", bus_if.req_addr, 32'h108);
        check("c2_inst_valid", bus_if.inst_valid, 1);
        check("c2_inst_pc", bus_if.inst_pc, 32'h100);
        c0 = n_cons;
        repeat (8) tick();
        check("throughput", 32'(n_cons - c0), 8);

        // Core stalled: credits stop issue at DEPTH, then release drains in order.
        reset_dut();
        bus_if.inst_ready = 1'b0;
        a0 = n_acc;
        repeat (10) tick();
        check("full_accepts", 32'(n_acc - a0), 4);
        check("full_req_valid", bus_if.req_valid, 0);
        check("full_inst_valid", bus_if.inst_valid, 1);
        bus_if.inst_ready = 1'b1;
        c0 = n_cons;
        repeat (10) tick();
        check("drain_ge4", 32'(n_cons - c0 >= 4), 1);
        check("issue_resumed", 32'(n_acc - a0 > 4), 1);

        // Redirect with two stale requests in flight on a 3-cycle bus.
        lat = 3;
        reset_dut();
        tick();
        do_redirect(32'h200);
        check("rd3_req_addr", bus_if.req_addr, 32'h200);
        check("rd3_inst_valid_n1", bus_if.inst_valid, 0);
        tick();
        check("rd3_inst_valid_n2", bus_if.inst_valid, 0);
        c0 = n_cons;
        repeat (12) tick();
        check("rd3_progress", 32'(n_cons > c0), 1);

        // Redirect coinciding with a response and a consume.
        lat = 1;
        reset_dut();
        repeat (5) tick();
        check("pre_rd_inst_valid", bus_if.inst_valid, 1);
        do_redirect(32'h400);
        check("rd_inst_valid_n1", bus_if.inst_valid, 0);
        check("rd_req_addr_n1", bus_if.req_addr, 32'h400);
        repeat (10) tick();

        // Address wrap at the top of the 32-bit space.
        do_redirect(32'hFFFF_FFFC);
        check("wrap_addr0", bus_if.req_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr1", bus_if.req_addr, 32'h0);
        repeat (6) tick();
        bus_if.req_ready = 1'b0;
        repeat (6) tick();
        check("no_lost_1", 32'(sb.size()), 0);
        check("idle_inst_valid", bus_if.inst_valid, 0);
        bus_if.req_ready = 1'b1;

        // Misaligned redirect target.
        repeat (3) tick();
        do_redirect(32'h202);
`ifdef RV_FETCH_ALIGN_CHECK_EN
        check("halt_misaligned", misaligned, 1);
        check("halt_req_valid", bus_if.req_valid, 0);
        repeat (4) tick();
        check("halt_hold_req_valid", bus_if.req_valid, 0);
        check("halt_inst_valid", bus_if.inst_valid, 0);
        check("halt_hold_misaligned", misaligned, 1);
        do_redirect(32'h300);
        check("resume_misaligned", misaligned, 0);
        check("resume_req_valid", bus_if.req_valid, 1);
        check("resume_req_addr", bus_if.req_addr, 32'h300);
`else
        check("align_req_addr", bus_if.req_addr, 32'h200);
        check("align_req_valid", bus_if.req_valid, 1);
`endif
        c0 = n_cons;
        repeat (8) tick();
        check("post_align_progress", 32'(n_cons > c0), 1);
        bus_if.req_ready = 1'b0;
        repeat (6) tick();
        check("no_lost_2", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
